stage_wb: RTL and testbench

Write-back stage and pipeline-hold controller for the 5-stage core. It produces the register-file write port (w_regs_en/addr/data) and the ctrl_stall bubble request that the decode stage consumes.
- Contains the MEM/WB pipeline register.
- Extracts and sign- or zero-extends load data.
- Detects load-use hazards.
- Runs a wait-state FSM that freezes the front of the pipeline while a multi-cycle data-memory load completes.

---
 rtl/stage_wb_if.sv | 32 +++
 rtl/stage_wb.sv | 120 ++++++++++++
 tb/tb_stage_wb.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_wb_if.sv
// Write-back stage bus: MEM-stage operands, hazard sources from EX/ID,
// register-file write port and the two pipeline-control requests.
interface stage_wb_if;
   logic        me_regs_write;
   logic        me_mem2reg;
   logic        me_mem_read;
   logic [4:0]  me_rd;
   logic [2:0]  me_func3;
   logic [31:0] me_alu_result;
   logic [31:0] me_mem_rdata;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        w_regs_en;
   logic [4:0]  w_regs_addr;
   logic [31:0] w_regs_data;
   logic        ctrl_stall;
   logic        pipe_hold;

   modport master (
      output me_regs_write, me_mem2reg, me_mem_read, me_rd, me_func3,
             me_alu_result, me_mem_rdata, ex_mem_read, ex_rd, id_rs1, id_rs2,
      input  w_regs_en, w_regs_addr, w_regs_data, ctrl_stall, pipe_hold
   );

   modport slave (
      input  me_regs_write, me_mem2reg, me_mem_read, me_rd, me_func3,
             me_alu_result, me_mem_rdata, ex_mem_read, ex_rd, id_rs1, id_rs2,
      output w_regs_en, w_regs_addr, w_regs_data, ctrl_stall, pipe_hold
   );
endinterface

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, load extraction, load-use hazard
// detection and the memory wait-state controller.
//
// state  | meaning
// S_IDLE | no multi-cycle load outstanding; a load entering MEM starts a wait
// S_WAIT | load in MEM waiting for read data; cnt = remaining hold cycles
module stage_wb #(
   parameter int unsigned LOAD_LATENCY = 2
) (
   input logic       clk,
   input logic       rst,
   stage_wb_if.slave bus
);

   localparam bit         WAIT_EN  = (LOAD_LATENCY != 0);
   localparam logic [3:0] CNT_INIT = WAIT_EN ? 4'(LOAD_LATENCY - 1) : 4'd0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        wait_start;
   logic        hold;

   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] res;

   logic        wb_regs_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   assign wait_start = (state_q == S_IDLE) & bus.me_mem_read & WAIT_EN;
   assign hold       = wait_start | ((state_q == S_WAIT) & (cnt_q != 4'd0));

   // Wait-state sequencer: hold the front of the pipe until load data is valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wait_start) begin
                  state_q <= S_WAIT;
                  cnt_q   <= CNT_INIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   assign off = bus.me_alu_result[1:0];

   // Byte/halfword lane select and sign/zero extension of the read word
   always_comb begin
      ld_byte = 8'd0;
      case (off)
         2'd0: ld_byte = bus.me_mem_rdata[7:0];
         2'd1: ld_byte = bus.me_mem_rdata[15:8];
         2'd2: ld_byte = bus.me_mem_rdata[23:16];
         2'd3: ld_byte = bus.me_mem_rdata[31:24];
         default: ld_byte = 8'd0;
      endcase
      // off[0] deliberately ignored: misaligned halfwords are not trapped
      ld_half = off[1] ? bus.me_mem_rdata[31:16] : bus.me_mem_rdata[15:0];
      ld_data = bus.me_mem_rdata;
      case (bus.me_func3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = bus.me_mem_rdata;
      endcase
   end

   assign res = bus.me_mem2reg ? ld_data : bus.me_alu_result;

   // MEM/WB register; a hold inserts a bubble but keeps the stale rd/data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_regs_write <= 1'b0;
         wb_rd         <= 5'd0;
         wb_data       <= 32'd0;
      end else if (hold) begin
         wb_regs_write <= 1'b0;
      end else begin
         wb_regs_write <= bus.me_regs_write;
         wb_rd         <= bus.me_rd;
         wb_data       <= res;
      end
   end

   assign bus.w_regs_en   = wb_regs_write & (wb_rd != 5'd0);
   assign bus.w_regs_addr = wb_rd;
   assign bus.w_regs_data = wb_data;
   assign bus.pipe_hold   = hold;

   // Load-use bubble is redundant while ID/EX is frozen by the memory wait
   assign bus.ctrl_stall = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                           ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2)) &
                           ~hold;

endmodule

// File: tb/tb_stage_wb.sv
// Bench for stage_wb: one instance with single-cycle memory, one with a
// two-cycle wait, both compared against an occupancy-based reference model.
module tb_stage_wb;
   localparam int L2 = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stage_wb_if bus0 ();
   stage_wb_if bus2 ();

   stage_wb #(.LOAD_LATENCY(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   stage_wb #(.LOAD_LATENCY(L2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   int n_cmp = 0;
   int n_err = 0;

   logic        e0_en, e2_en;
   logic [4:0]  e0_addr, e2_addr;
   logic [31:0] e0_data, e2_data;

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      int unsigned off = addr % 4;
      int unsigned b = (word >> (8 * off)) % 256;
      int unsigned h = (word >> (16 * (off / 2))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
         3'd4:    return 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
         3'd5:    return 32'(h);
         default: return word;
      endcase
   endfunction

   task automatic drive0(input bit rw, input bit m2r, input bit mr, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata);
      bus0.me_regs_write = rw;  bus0.me_mem2reg = m2r; bus0.me_mem_read = mr;
      bus0.me_rd = rd; bus0.me_func3 = f3; bus0.me_alu_result = alu; bus0.me_mem_rdata = rdata;
   endtask

   task automatic drive2(input bit rw, input bit m2r, input bit mr, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata);
      bus2.me_regs_write = rw;  bus2.me_mem2reg = m2r; bus2.me_mem_read = mr;
      bus2.me_rd = rd; bus2.me_func3 = f3; bus2.me_alu_result = alu; bus2.me_mem_rdata = rdata;
   endtask

   task automatic hz0(input bit emr, input logic [4:0] erd, input logic [4:0] rs1, input logic [4:0] rs2);
      bus0.ex_mem_read = emr; bus0.ex_rd = erd; bus0.id_rs1 = rs1; bus0.id_rs2 = rs2;
   endtask

   task automatic hz2(input bit emr, input logic [4:0] erd, input logic [4:0] rs1, input logic [4:0] rs2);
      bus2.ex_mem_read = emr; bus2.ex_rd = erd; bus2.id_rs1 = rs1; bus2.id_rs2 = rs2;
   endtask

   task automatic clear_inputs();
      drive0(0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0);
      drive2(0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0);
      hz0(0, 5'd0, 5'd0, 5'd0);
      hz2(0, 5'd0, 5'd0, 5'd0);
   endtask

   // Quiet cycles: any pending wait drains and both WB registers capture zeros
   task automatic idle(input int n);
      @(negedge clk);
      clear_inputs();
      repeat (n) @(posedge clk);
      e0_en = 0; e0_addr = 0; e0_data = 0;
      e2_en = 0; e2_addr = 0; e2_data = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive0(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), $urandom, $urandom);
         drive2(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), $urandom, $urandom);
         hz0(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         hz2(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         #1;
         n_cmp++;
         if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_wb0: got en=%b addr=%0d data=%h, want all zero",
                     bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data);
         end
         n_cmp++;
         if ({bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_wb2: got en=%b addr=%0d data=%h, want all zero",
                     bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data);
         end
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      e0_en = 0; e0_addr = 0; e0_data = 0;
      e2_en = 0; e2_addr = 0; e2_data = 0;
      repeat (2) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data, bus2.pipe_hold, bus2.ctrl_stall} !== 40'd0) begin
            n_err++;
            $display("FAIL reset_release2: got en=%b addr=%0d data=%h hold=%b stall=%b, want all zero",
                     bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data, bus2.pipe_hold, bus2.ctrl_stall);
         end
         n_cmp++;
         if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, bus0.pipe_hold} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_release0: got en=%b addr=%0d data=%h hold=%b, want all zero",
                     bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, bus0.pipe_hold);
         end
      end
   endtask

   task automatic test_alu_wb();
      bit rw;
      logic [4:0]  rd;
      logic [31:0] alu;
      for (int i = 0; i < 24; i++) begin
         rw = 1'($urandom); rd = 5'($urandom); alu = $urandom;
         if (i == 0) begin rw = 1; rd = 5'd5; alu = 32'h1234_5678; end
         if (i == 1) begin rw = 1; rd = 5'd0; alu = 32'h1234_5678; end
         @(negedge clk);
         n_cmp++;
         if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data} !== {e0_en, e0_addr, e0_data}) begin
            n_err++;
            $display("FAIL alu_wb0[%0d]: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h", i,
                     bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, e0_en, e0_addr, e0_data);
         end
         n_cmp++;
         if ({bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data} !== {e2_en, e2_addr, e2_data}) begin
            n_err++;
            $display("FAIL alu_wb2[%0d]: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h", i,
                     bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data, e2_en, e2_addr, e2_data);
         end
         drive0(rw, 0, 0, rd, 3'($urandom), alu, $urandom);
         drive2(rw, 0, 0, rd, 3'($urandom), alu, $urandom);
         e0_en = rw && (rd != 0); e0_addr = rd; e0_data = alu;
         e2_en = rw && (rd != 0); e2_addr = rd; e2_data = alu;
      end
      @(negedge clk);
      n_cmp++;
      if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data} !== {e0_en, e0_addr, e0_data}) begin
         n_err++;
         $display("FAIL alu_wb0_last: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
                  bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, e0_en, e0_addr, e0_data);
      end
   endtask

   task automatic test_load_extract();
      logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_7F01, 32'h80FF_7F01};
      logic [2:0]  f3_tab  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] a_tab   [5] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002,
                                   32'h1000_0000, 32'h1000_0000};
      logic [31:0] w, a;
      logic [2:0]  f3;
      logic [4:0]  rd;
      for (int i = 0; i < 40; i++) begin
         rd = 5'($urandom_range(1, 31));
         if (i < 5) begin
            w = 32'h80FF_7F01; f3 = f3_tab[i]; a = a_tab[i];
         end else begin
            w = $urandom; f3 = 3'($urandom); a = $urandom;
         end
         @(negedge clk);
         n_cmp++;
         if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data} !== {e0_en, e0_addr, e0_data}) begin
            n_err++;
            $display("FAIL extract[%0d]: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h", i,
                     bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, e0_en, e0_addr, e0_data);
         end
         drive0(1, 1, 1, rd, f3, a, w);
         #1;
         n_cmp++;
         if (bus0.pipe_hold !== 1'b0) begin
            n_err++;
            $display("FAIL extract_nohold[%0d]: got pipe_hold=%b, want 0", i, bus0.pipe_hold);
         end
         e0_en = 1; e0_addr = rd;
         e0_data = (i < 5) ? exp_tab[i] : ref_load(f3, a, w);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data} !== {e0_en, e0_addr, e0_data}) begin
         n_err++;
         $display("FAIL extract_last: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
                  bus0.w_regs_en, bus0.w_regs_addr, bus0.w_regs_data, e0_en, e0_addr, e0_data);
      end
   endtask

   // One instruction through MEM of the waiting instance: a load sits there
   // L2+1 cycles (held for the first L2), anything else one cycle.
   task automatic issue2(input bit rw, input bit m2r, input bit mr, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input bit force_haz);
      int occ = mr ? L2 + 1 : 1;
      bit exp_hold, exp_stall;
      logic       emr;
      logic [4:0] erd, rs1, rs2;
      for (int k = 0; k < occ; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data} !== {e2_en, e2_addr, e2_data}) begin
            n_err++;
            $display("FAIL wb2 rd=%0d k=%0d: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
                     rd, k, bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data, e2_en, e2_addr, e2_data);
         end
         emr = 1'($urandom); erd = 5'($urandom_range(0, 3));
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         if (force_haz) begin emr = 1; erd = 5'd3; rs1 = 5'd9; rs2 = 5'd3; end
         drive2(rw, m2r, mr, rd, f3, alu, rdata);
         hz2(emr, erd, rs1, rs2);
         #1;
         exp_hold  = (k < occ - 1);
         exp_stall = emr && (erd != 0) && (erd == rs1 || erd == rs2) && !exp_hold;
         n_cmp++;
         if (bus2.pipe_hold !== exp_hold) begin
            n_err++;
            $display("FAIL pipe_hold rd=%0d k=%0d: got %b, want %b", rd, k, bus2.pipe_hold, exp_hold);
         end
         n_cmp++;
         if (bus2.ctrl_stall !== exp_stall) begin
            n_err++;
            $display("FAIL ctrl_stall2 k=%0d: got %b, want %b", k, bus2.ctrl_stall, exp_stall);
         end
         if (exp_hold) begin
            e2_en = 0;
         end else begin
            e2_en = rw && (rd != 0); e2_addr = rd;
            e2_data = m2r ? ref_load(f3, alu, rdata) : alu;
         end
      end
   endtask

   task automatic test_wait_fsm();
      idle(4);
      issue2(0, 0, 0, 5'd0, 3'd2, 32'h0, 32'h0, 0);
      issue2(1, 1, 1, 5'd7, 3'd2, 32'h2000_0000, 32'hCAFE_F00D, 1);
      issue2(0, 0, 0, 5'd2, 3'd2, 32'h5, 32'h0, 1);
      issue2(0, 0, 0, 5'd0, 3'd2, 32'h0, 32'h0, 0);
   endtask

   task automatic test_back_to_back();
      bit mr;
      idle(4);
      issue2(1, 1, 1, 5'd10, 3'd0, 32'h0000_0001, 32'h1234_8056, 0);
      issue2(1, 1, 1, 5'd11, 3'd5, 32'h0000_0002, 32'hFEDC_BA98, 0);
      for (int i = 0; i < 40; i++) begin
         mr = ($urandom_range(0, 2) == 0);
         issue2(1'($urandom), mr, mr, 5'($urandom), 3'($urandom), $urandom, $urandom, 0);
      end
      issue2(0, 0, 0, 5'd0, 3'd0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_load_use();
      logic       emr;
      logic [4:0] erd, rs1, rs2;
      bit         exp_stall;
      idle(4);
      for (int i = 0; i < 36; i++) begin
         case (i)
            0:       begin emr = 1; erd = 5'd3; rs1 = 5'd8; rs2 = 5'd3; end
            1:       begin emr = 1; erd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; end
            2:       begin emr = 1; erd = 5'd3; rs1 = 5'd4; rs2 = 5'd5; end
            3:       begin emr = 0; erd = 5'd3; rs1 = 5'd3; rs2 = 5'd3; end
            4:       begin emr = 1; erd = 5'd3; rs1 = 5'd3; rs2 = 5'd6; end
            default: begin
               emr = 1'($urandom); erd = 5'($urandom_range(0, 3));
               rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            end
         endcase
         @(negedge clk);
         hz0(emr, erd, rs1, rs2);
         #1;
         exp_stall = emr && (erd != 0) && (erd == rs1 || erd == rs2);
         n_cmp++;
         if (bus0.ctrl_stall !== exp_stall) begin
            n_err++;
            $display("FAIL load_use[%0d]: got ctrl_stall=%b, want %b", i, bus0.ctrl_stall, exp_stall);
         end
      end
      hz0(0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic test_reset_mid_wait();
      idle(4);
      @(negedge clk);
      drive2(1, 1, 1, 5'd9, 3'd2, 32'h40, 32'h1357_9BDF);
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus2.pipe_hold !== 1'b1) begin
         n_err++;
         $display("FAIL midwait_hold: got pipe_hold=%b, want 1", bus2.pipe_hold);
      end
      rst = 1'b0;
      clear_inputs();
      #1;
      n_cmp++;
      if ({bus2.pipe_hold, bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data} !== 39'd0) begin
         n_err++;
         $display("FAIL midwait_reset: got hold=%b en=%b addr=%0d data=%h, want all zero",
                  bus2.pipe_hold, bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({bus2.pipe_hold, bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data} !== 39'd0) begin
            n_err++;
            $display("FAIL midwait_after[%0d]: got hold=%b en=%b addr=%0d data=%h, want all zero", i,
                     bus2.pipe_hold, bus2.w_regs_en, bus2.w_regs_addr, bus2.w_regs_data);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_alu_wb();
      test_load_extract();
      test_wait_fsm();
      test_back_to_back();
      test_load_use();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
